data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory between the processor and the UART debug controller.
//  CPU has fixed priority; a starvation counter guarantees the debug port a slot within MAX_WAIT cycles.

---
 rtl/data_mem_arbiter_pkg.sv | 17 +
 rtl/data_mem_arbiter_mem_read_tracker.sv | 39 +++
 rtl/data_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and limits for the data memory arbiter: read ownership tag,
// supported RAM latency range and a saturating counter helper.
package data_mem_arbiter_pkg;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_mem_read_tracker.sv
// Shift register carrying {valid, owner} for every issued read so the
// returning RAM data can be steered to the master that asked for it.
module mem_read_tracker
    import data_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic issue_valid,
    input  logic issue_owner,
    output logic out_valid,
    output logic out_owner
);

    logic [LATENCY-1:0] valid_sr;
    owner_t             owner_sr [LATENCY];

    // Clearing on reset drops reads that were still in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_sr <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                owner_sr[i] <= OWNER_CPU;
            end
        end else begin
            valid_sr[0] <= issue_valid;
            owner_sr[0] <= owner_t'(issue_owner);
            for (int i = 1; i < LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                owner_sr[i] <= owner_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[LATENCY-1];
    assign out_owner = owner_sr[LATENCY-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU and the debug port:
// CPU priority, bounded debug starvation, tagged read return.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE        = 18,
    parameter int ADDR_WIDTH       = 16,
    parameter int MEM_READ_LATENCY = 1,
    parameter int MAX_WAIT         = 7
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_rvalid,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0]  dbg_wdata,
    output logic                  dbg_ack,
    output logic                  dbg_rvalid,
    output logic [WORD_SIZE-1:0]  dbg_rdata,
    input  logic                  cpu_halted,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_SIZE-1:0]  mem_write,
    output logic                  mem_wren,
    input  logic [WORD_SIZE-1:0]  mem_read,
    output logic [15:0]           conflict_count
);

    localparam int LATENCY =
        (MEM_READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
        (MEM_READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : MEM_READ_LATENCY;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    // Handshake: a master raises req with we/addr/wdata stable and holds them
    // until ack; ack is combinational and marks the single cycle the access
    // reaches the RAM. Read data returns later as a one-cycle rvalid pulse.
    logic [7:0]            wait_cnt;
    logic                  dbg_win;
    logic                  cpu_win;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic                  issue_read;
    owner_t                issue_owner;
    logic                  ret_valid;
    logic                  ret_owner;
    logic [WORD_SIZE-1:0]  cpu_rdata_q;
    logic [WORD_SIZE-1:0]  dbg_rdata_q;

    always_comb begin
        dbg_win = reset_n && dbg_req && (!cpu_req || cpu_halted || wait_cnt == WAIT_LIMIT);
        cpu_win = reset_n && cpu_req && !dbg_win;
    end

    assign dbg_ack = dbg_win;
    assign cpu_ack = cpu_win;

    // When idle the RAM keeps seeing the last granted address and data.
    always_comb begin
        mem_address = addr_q;
        mem_write   = wdata_q;
        mem_wren    = 1'b0;
        issue_read  = 1'b0;
        issue_owner = OWNER_CPU;
        if (dbg_win) begin
            mem_address = dbg_addr;
            mem_write   = dbg_wdata;
            mem_wren    = dbg_we;
            issue_read  = !dbg_we;
            issue_owner = OWNER_DBG;
        end else if (cpu_win) begin
            mem_address = cpu_addr;
            mem_write   = cpu_wdata;
            mem_wren    = cpu_we;
            issue_read  = !cpu_we;
        end
        if (!reset_n) begin
            mem_address = '0;
            mem_write   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            wait_cnt       <= '0;
            conflict_count <= '0;
        end else begin
            if (cpu_win || dbg_win) begin
                addr_q  <= mem_address;
                wdata_q <= mem_write;
            end
            if (!dbg_req || dbg_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (cpu_req && dbg_req) begin
                conflict_count <= sat_inc16(conflict_count);
            end
        end
    end

    mem_read_tracker #(
        .LATENCY(LATENCY)
    ) u_tracker (
        .clock      (clock),
        .reset_n    (reset_n),
        .issue_valid(issue_read),
        .issue_owner(issue_owner),
        .out_valid  (ret_valid),
        .out_owner  (ret_owner)
    );

    assign cpu_rvalid = reset_n && ret_valid && (ret_owner == OWNER_CPU);
    assign dbg_rvalid = reset_n && ret_valid && (ret_owner == OWNER_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_read : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_read : dbg_rdata_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_read;
            if (dbg_rvalid) dbg_rdata_q <= mem_read;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (RAM latency 1 and 3) share the
// same stimulus; a scoreboard matches every returned read against a RAM model.
module tb_data_mem_arbiter;

    localparam int W        = 18;
    localparam int AW       = 16;
    localparam int MAX_WAIT = 7;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, cpu_halted = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [W-1:0]  cpu_wdata = '0, dbg_wdata = '0;

    logic          cpu_ack_1, cpu_rvalid_1, dbg_ack_1, dbg_rvalid_1, mem_wren_1;
    logic [W-1:0]  cpu_rdata_1, dbg_rdata_1, mem_write_1, mem_read_1;
    logic [AW-1:0] mem_address_1;
    logic [15:0]   conflict_count_1;
    logic          cpu_ack_3, cpu_rvalid_3, dbg_ack_3, dbg_rvalid_3, mem_wren_3;
    logic [W-1:0]  cpu_rdata_3, dbg_rdata_3, mem_write_3, mem_read_3;
    logic [AW-1:0] mem_address_3;
    logic [15:0]   conflict_count_3;

    int            checks = 0;
    int            errors = 0;
    logic [W:0]    exp1_q[$];
    logic [W:0]    exp3_q[$];
    logic [15:0]   conf_model = '0;
    logic [W-1:0]  ref_mem [65536];
    bit            ref_wr  [65536];

    always #5 clock = ~clock;

    data_mem_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(AW), .MEM_READ_LATENCY(1), .MAX_WAIT(MAX_WAIT)) dut_1 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_1), .cpu_rvalid(cpu_rvalid_1), .cpu_rdata(cpu_rdata_1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack_1), .dbg_rvalid(dbg_rvalid_1), .dbg_rdata(dbg_rdata_1),
        .cpu_halted(cpu_halted), .mem_address(mem_address_1), .mem_write(mem_write_1),
        .mem_wren(mem_wren_1), .mem_read(mem_read_1), .conflict_count(conflict_count_1)
    );

    data_mem_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(AW), .MEM_READ_LATENCY(3), .MAX_WAIT(MAX_WAIT)) dut_3 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_3), .cpu_rvalid(cpu_rvalid_3), .cpu_rdata(cpu_rdata_3),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack_3), .dbg_rvalid(dbg_rvalid_3), .dbg_rdata(dbg_rdata_3),
        .cpu_halted(cpu_halted), .mem_address(mem_address_3), .mem_write(mem_write_3),
        .mem_wren(mem_wren_3), .mem_read(mem_read_3), .conflict_count(conflict_count_3)
    );

    function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
        return {a[1:0], a} ^ 18'h2A5C3;
    endfunction

    function logic [W-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    // RAM models: unwritten words read back as init_val(address).
    logic [W-1:0] ram1 [65536];
    bit           wr1  [65536];
    logic [W-1:0] rd1;
    logic [W-1:0] ram3 [65536];
    bit           wr3  [65536];
    logic [W-1:0] pipe3 [3];

    always @(posedge clock) begin
        if (mem_wren_1) begin
            ram1[mem_address_1] <= mem_write_1;
            wr1[mem_address_1]  <= 1'b1;
        end
        rd1 <= wr1[mem_address_1] ? ram1[mem_address_1] : init_val(mem_address_1);
        if (mem_wren_3) begin
            ram3[mem_address_3] <= mem_write_3;
            wr3[mem_address_3]  <= 1'b1;
        end
        pipe3[0] <= wr3[mem_address_3] ? ram3[mem_address_3] : init_val(mem_address_3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign mem_read_1 = rd1;
    assign mem_read_3 = pipe3[2];

    // Scoreboard: pop/compare returned reads, track conflicts, push new reads.
    always @(negedge clock) begin : monitor
        logic [W:0] got;
        logic [W:0] exp;
        if (!reset_n) begin
            exp1_q.delete();
            exp3_q.delete();
            conf_model = '0;
        end else begin
            if (cpu_rvalid_1 || dbg_rvalid_1) begin
                checks++;
                got = {dbg_rvalid_1, dbg_rvalid_1 ? dbg_rdata_1 : cpu_rdata_1};
                if (cpu_rvalid_1 && dbg_rvalid_1) begin
                    errors++;
                    $display("FAIL lat1_rvalid_both: cpu_rvalid=1 dbg_rvalid=1, required at most one");
                end else if (exp1_q.size() == 0) begin
                    errors++;
                    $display("FAIL lat1_unexpected_rvalid: got owner/data %h, required no rvalid", got);
                end else begin
                    exp = exp1_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL lat1_read_return: got owner/data %h, required %h", got, exp);
                    end
                end
            end
            if (cpu_rvalid_3 || dbg_rvalid_3) begin
                checks++;
                got = {dbg_rvalid_3, dbg_rvalid_3 ? dbg_rdata_3 : cpu_rdata_3};
                if (cpu_rvalid_3 && dbg_rvalid_3) begin
                    errors++;
                    $display("FAIL lat3_rvalid_both: cpu_rvalid=1 dbg_rvalid=1, required at most one");
                end else if (exp3_q.size() == 0) begin
                    errors++;
                    $display("FAIL lat3_unexpected_rvalid: got owner/data %h, required no rvalid", got);
                end else begin
                    exp = exp3_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL lat3_read_return: got owner/data %h, required %h", got, exp);
                    end
                end
            end
            checks++;
            if (conflict_count_1 !== conf_model || conflict_count_3 !== conf_model) begin
                errors++;
                $display("FAIL conflict_count: got %0d/%0d, required %0d", conflict_count_1, conflict_count_3, conf_model);
            end
            if (cpu_req && dbg_req && conf_model != 16'hFFFF) conf_model = conf_model + 16'd1;
            if (dbg_ack_1) begin
                if (dbg_we) begin
                    ref_mem[dbg_addr] = dbg_wdata;
                    ref_wr[dbg_addr]  = 1'b1;
                end else begin
                    exp1_q.push_back({1'b1, ref_read(dbg_addr)});
                    exp3_q.push_back({1'b1, ref_read(dbg_addr)});
                end
            end else if (cpu_ack_1) begin
                if (cpu_we) begin
                    ref_mem[cpu_addr] = cpu_wdata;
                    ref_wr[cpu_addr]  = 1'b1;
                end else begin
                    exp1_q.push_back({1'b0, ref_read(cpu_addr)});
                    exp3_q.push_back({1'b0, ref_read(cpu_addr)});
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; cpu_halted = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 18'h2AAAA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h4321; dbg_wdata = 18'h15555;
        next_cycle();
        @(negedge clock);
        checks += 5;
        if ({cpu_ack_1, dbg_ack_1, cpu_ack_3, dbg_ack_3} !== 4'b0) begin
            errors++; $display("FAIL reset_acks: got %b, required 0000", {cpu_ack_1, dbg_ack_1, cpu_ack_3, dbg_ack_3});
        end
        if ({cpu_rvalid_1, dbg_rvalid_1, mem_wren_1, mem_wren_3} !== 4'b0) begin
            errors++; $display("FAIL reset_rvalid_wren: got %b, required 0000", {cpu_rvalid_1, dbg_rvalid_1, mem_wren_1, mem_wren_3});
        end
        if (mem_address_1 !== 16'h0 || mem_address_3 !== 16'h0) begin
            errors++; $display("FAIL reset_mem_address: got %h/%h, required 0", mem_address_1, mem_address_3);
        end
        if (mem_write_1 !== 18'h0) begin
            errors++; $display("FAIL reset_mem_write: got %h, required 0", mem_write_1);
        end
        if (conflict_count_1 !== 16'h0) begin
            errors++; $display("FAIL reset_conflict_count: got %0d, required 0", conflict_count_1);
        end
        next_cycle();
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clock);
        checks++;
        if ({cpu_ack_1, dbg_ack_1, mem_wren_1} !== 3'b0) begin
            errors++; $display("FAIL post_reset_idle: got %b, required 000", {cpu_ack_1, dbg_ack_1, mem_wren_1});
        end
        next_cycle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clock);
        checks += 2;
        if (cpu_ack_1 !== 1'b1 || dbg_ack_1 !== 1'b0) begin
            errors++; $display("FAIL cpu_read_ack: got cpu=%b dbg=%b, required cpu=1 dbg=0", cpu_ack_1, dbg_ack_1);
        end
        if (mem_address_1 !== 16'h0010 || mem_wren_1 !== 1'b0) begin
            errors++; $display("FAIL cpu_read_issue: got addr=%h wren=%b, required addr=0010 wren=0", mem_address_1, mem_wren_1);
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clock);
        checks += 3;
        if (cpu_rvalid_1 !== 1'b1 || dbg_rvalid_1 !== 1'b0) begin
            errors++; $display("FAIL cpu_read_rvalid: got cpu=%b dbg=%b, required cpu=1 dbg=0", cpu_rvalid_1, dbg_rvalid_1);
        end
        if (cpu_rdata_1 !== init_val(16'h0010)) begin
            errors++; $display("FAIL cpu_read_data: got %h, required %h", cpu_rdata_1, init_val(16'h0010));
        end
        if (mem_address_1 !== 16'h0010) begin
            errors++; $display("FAIL idle_address_hold: got %h, required 0010", mem_address_1);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (cpu_rvalid_1 !== 1'b0) begin
            errors++; $display("FAIL cpu_rvalid_pulse: got %b, required 0", cpu_rvalid_1);
        end
        next_cycle();
    endtask

    task automatic test_write_then_read();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0005; dbg_wdata = 18'h3FFFF;
        @(negedge clock);
        checks += 2;
        if (dbg_ack_1 !== 1'b1 || cpu_ack_1 !== 1'b0 || mem_wren_1 !== 1'b1) begin
            errors++; $display("FAIL dbg_write_ack: got dbg=%b cpu=%b wren=%b, required 1 0 1", dbg_ack_1, cpu_ack_1, mem_wren_1);
        end
        if (mem_address_1 !== 16'h0005 || mem_write_1 !== 18'h3FFFF) begin
            errors++; $display("FAIL dbg_write_bus: got addr=%h data=%h, required 0005 3ffff", mem_address_1, mem_write_1);
        end
        next_cycle();
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        @(negedge clock);
        checks++;
        if (cpu_ack_1 !== 1'b1) begin
            errors++; $display("FAIL cpu_read_after_write_ack: got %b, required 1", cpu_ack_1);
        end
        next_cycle();
        cpu_req = 1'b0;
        for (int c = 2; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (dbg_rvalid_1 !== 1'b0 || dbg_rvalid_3 !== 1'b0) begin
                errors++; $display("FAIL write_no_rvalid: cycle %0d got %b/%b, required 0", c, dbg_rvalid_1, dbg_rvalid_3);
            end
            if (c == 2) begin
                checks++;
                if (cpu_rvalid_1 !== 1'b1 || cpu_rdata_1 !== 18'h3FFFF) begin
                    errors++; $display("FAIL lat1_read_after_write: got v=%b d=%h, required 1 3ffff", cpu_rvalid_1, cpu_rdata_1);
                end
            end
            if (c == 4) begin
                checks++;
                if (cpu_rvalid_3 !== 1'b1 || cpu_rdata_3 !== 18'h3FFFF) begin
                    errors++; $display("FAIL lat3_read_after_write: got v=%b d=%h, required 1 3ffff", cpu_rvalid_3, cpu_rdata_3);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0021;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            checks++;
            if (dbg_ack_1 !== ((k % 8) == 7) || cpu_ack_1 !== ((k % 8) != 7)) begin
                errors++; $display("FAIL starvation_grant: cycle %0d got cpu=%b dbg=%b, required dbg=%b", k, cpu_ack_1, dbg_ack_1, (k % 8) == 7);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_halted();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0031;
        cpu_halted = 1'b1;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checks += 2;
            if (dbg_ack_1 !== 1'b1 || cpu_ack_1 !== 1'b0) begin
                errors++; $display("FAIL halted_grant: cycle %0d got cpu=%b dbg=%b, required cpu=0 dbg=1", k, cpu_ack_1, dbg_ack_1);
            end
            if (conflict_count_1 !== 16'(k)) begin
                errors++; $display("FAIL halted_conflict_count: got %0d, required %0d", conflict_count_1, k);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_latency3_alternating();
        for (int i = 0; i < 4; i++) next_cycle();
        for (int t = 0; t < 9; t++) begin
            idle_inputs();
            if (t < 4) begin
                if (t % 2 == 0) begin
                    cpu_req = 1'b1; cpu_addr = 16'(256 + t);
                end else begin
                    dbg_req = 1'b1; dbg_addr = 16'(256 + t);
                end
            end
            @(negedge clock);
            checks += 2;
            if (cpu_rvalid_3 !== (t == 3 || t == 5) || dbg_rvalid_3 !== (t == 4 || t == 6)) begin
                errors++; $display("FAIL lat3_alternate_order: cycle %0d got cpu=%b dbg=%b", t, cpu_rvalid_3, dbg_rvalid_3);
            end
            if (cpu_rvalid_1 !== (t == 1 || t == 3) || dbg_rvalid_1 !== (t == 2 || t == 4)) begin
                errors++; $display("FAIL lat1_alternate_order: cycle %0d got cpu=%b dbg=%b", t, cpu_rvalid_1, dbg_rvalid_1);
            end
            if (t == 3 || t == 5) begin
                checks++;
                if (cpu_rdata_3 !== init_val(16'(253 + t))) begin
                    errors++; $display("FAIL lat3_cpu_data: got %h, required %h", cpu_rdata_3, init_val(16'(253 + t)));
                end
            end
            if (t == 4 || t == 6) begin
                checks += 2;
                if (dbg_rdata_3 !== init_val(16'(253 + t))) begin
                    errors++; $display("FAIL lat3_dbg_data: got %h, required %h", dbg_rdata_3, init_val(16'(253 + t)));
                end
                if (cpu_rdata_3 !== init_val(16'(252 + t))) begin
                    errors++; $display("FAIL lat3_cpu_rdata_hold: got %h, required %h", cpu_rdata_3, init_val(16'(252 + t)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random_traffic();
        int  tb_wait;
        logic exp_cpu, exp_dbg;
        logic cpu_done, dbg_done;
        idle_inputs();
        apply_reset();
        tb_wait = 0;
        cpu_done = 1'b1;
        dbg_done = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (cpu_done) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 31));
                cpu_wdata = 18'($urandom_range(0, 18'h3FFFF));
            end
            if (dbg_done) begin
                dbg_req   = ($urandom_range(0, 99) < 50);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 16'($urandom_range(0, 31));
                dbg_wdata = 18'($urandom_range(0, 18'h3FFFF));
            end
            cpu_halted = ($urandom_range(0, 9) == 0);
            exp_dbg = dbg_req && (!cpu_req || cpu_halted || tb_wait == MAX_WAIT);
            exp_cpu = cpu_req && !exp_dbg;
            @(negedge clock);
            checks += 2;
            if ({cpu_ack_1, dbg_ack_1} !== {exp_cpu, exp_dbg} || {cpu_ack_3, dbg_ack_3} !== {exp_cpu, exp_dbg}) begin
                errors++; $display("FAIL random_grant: cycle %0d got %b%b/%b%b, required %b%b", n, cpu_ack_1, dbg_ack_1, cpu_ack_3, dbg_ack_3, exp_cpu, exp_dbg);
            end
            if (mem_wren_1 !== ((exp_cpu && cpu_we) || (exp_dbg && dbg_we))) begin
                errors++; $display("FAIL random_wren: cycle %0d got %b", n, mem_wren_1);
            end
            if (!dbg_req || exp_dbg) tb_wait = 0;
            else if (tb_wait < MAX_WAIT) tb_wait++;
            cpu_done = !cpu_req || exp_cpu;
            dbg_done = !dbg_req || exp_dbg;
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) next_cycle();
    endtask

    task automatic test_reset_inflight();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0041;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            next_cycle();
        end
        reset_n = 1'b0;
        for (int c = 2; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if ({cpu_ack_1, dbg_ack_1, cpu_rvalid_1, dbg_rvalid_1, cpu_rvalid_3, dbg_rvalid_3} !== 6'b0) begin
                errors++; $display("FAIL reset_inflight_quiet: cycle %0d got %b, required 000000", c,
                    {cpu_ack_1, dbg_ack_1, cpu_rvalid_1, dbg_rvalid_1, cpu_rvalid_3, dbg_rvalid_3});
            end
            next_cycle();
        end
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k == 0) begin
                checks += 2;
                if (conflict_count_1 !== 16'h0 || conflict_count_3 !== 16'h0) begin
                    errors++; $display("FAIL reset_inflight_conflict: got %0d/%0d, required 0", conflict_count_1, conflict_count_3);
                end
                if ({cpu_rvalid_1, dbg_rvalid_1, cpu_rvalid_3, dbg_rvalid_3} !== 4'b0) begin
                    errors++; $display("FAIL reset_inflight_dropped: got %b, required 0000", {cpu_rvalid_1, dbg_rvalid_1, cpu_rvalid_3, dbg_rvalid_3});
                end
            end
            checks++;
            if (dbg_ack_1 !== (k == 7) || cpu_ack_1 !== (k != 7)) begin
                errors++; $display("FAIL reset_wait_cleared: cycle %0d got cpu=%b dbg=%b, required dbg=%b", k, cpu_ack_1, dbg_ack_1, k == 7);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_then_read();
        test_starvation();
        test_halted();
        test_latency3_alternating();
        test_random_traffic();
        test_reset_inflight();
        for (int i = 0; i < 6; i++) next_cycle();
        checks += 2;
        if (exp1_q.size() != 0) begin
            errors++; $display("FAIL lat1_drain: %0d reads outstanding, required 0", exp1_q.size());
        end
        if (exp3_q.size() != 0) begin
            errors++; $display("FAIL lat3_drain: %0d reads outstanding, required 0", exp3_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
